lcd_ctrl_param: RTL and testbench

Parametrised next-generation LCD image controller. It loads an IMG_W x IMG_H image from the instruction ROM (IROM) into an internal pixel buffer. It then applies 2x2-window commands: shift, average, mirror, and the new max/min, rotate and recenter operations. On the write command it streams the buffer to the image result buffer (IRB). It sits between the IROM/IRB macros and the host command interface, with the same handshake as the 8x8 controller it supersedes.

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_win_alu.sv | 69 ++++++
 rtl/lcd_ctrl_param.sv | 159 +++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ==================================================================
// lcd_pkg : shared command codes, FSM states, window index helper  (rev 1.0)
// ==================================================================
`default_nettype none

package lcd_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE  = 4'd0,
        CMD_UP     = 4'd1,
        CMD_DOWN   = 4'd2,
        CMD_LEFT   = 4'd3,
        CMD_RIGHT  = 4'd4,
        CMD_AVG    = 4'd5,
        CMD_MIRX   = 4'd6,
        CMD_MIRY   = 4'd7,
        CMD_MAX    = 4'd8,
        CMD_MIN    = 4'd9,
        CMD_ROTCW  = 4'd10,
        CMD_ROTCCW = 4'd11,
        CMD_CENTER = 4'd12,
        CMD_NOP13  = 4'd13,
        CMD_NOP14  = 4'd14,
        CMD_NOP15  = 4'd15
    } cmd_e;

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic int unsigned win_idx(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned w);
        return y * w + x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_win_alu.sv
// ==================================================================
// lcd_win_alu : combinational 2x2 window operator  (rev 1.0)
// ==================================================================
`default_nettype none

module lcd_win_alu
    import lcd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] tl,
    input  logic [DW-1:0] tr,
    input  logic [DW-1:0] bl,
    input  logic [DW-1:0] br,
    input  logic [3:0]    op,
    output logic [DW-1:0] new_tl,
    output logic [DW-1:0] new_tr,
    output logic [DW-1:0] new_bl,
    output logic [DW-1:0] new_br
);

    logic [DW+1:0] sum;
    logic [DW-1:0] avg;
    logic [DW-1:0] mx_t, mx_b, mx;
    logic [DW-1:0] mn_t, mn_b, mn;

    always_comb begin
        sum  = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
        avg  = DW'(sum >> 2);
        mx_t = (tl > tr) ? tl : tr;
        mx_b = (bl > br) ? bl : br;
        mx   = (mx_t > mx_b) ? mx_t : mx_b;
        mn_t = (tl < tr) ? tl : tr;
        mn_b = (bl < br) ? bl : br;
        mn   = (mn_t < mn_b) ? mn_t : mn_b;

        new_tl = tl;
        new_tr = tr;
        new_bl = bl;
        new_br = br;
        case (cmd_e'(op))
            CMD_AVG: begin
                new_tl = avg; new_tr = avg; new_bl = avg; new_br = avg;
            end
            CMD_MIRX: begin
                new_tl = bl; new_tr = br; new_bl = tl; new_br = tr;
            end
            CMD_MIRY: begin
                new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
            end
            CMD_MAX: begin
                new_tl = mx; new_tr = mx; new_bl = mx; new_br = mx;
            end
            CMD_MIN: begin
                new_tl = mn; new_tr = mn; new_bl = mn; new_br = mn;
            end
            CMD_ROTCW: begin
                new_tl = bl; new_tr = tl; new_br = tr; new_bl = br;
            end
            CMD_ROTCCW: begin
                new_tl = tr; new_tr = br; new_br = bl; new_bl = tl;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl_param.sv
// ==================================================================
// lcd_ctrl_param : parametrised LCD image controller top  (rev 1.0)
// ==================================================================
`default_nettype none

module lcd_ctrl_param
    import lcd_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] IROM_Q,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int LW = AW + 1;

    localparam logic [XW-1:0] X_MIN = XW'(1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_MID = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_MIN = YW'(1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_MID = YW'(IMG_H / 2);

    logic [2:0]    state;
    logic [LW-1:0] ld_cnt;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [DW-1:0] pix [N];

    logic [AW-1:0] idx_tl, idx_tr, idx_bl, idx_br, wr_next;
    logic [DW-1:0] new_tl, new_tr, new_bl, new_br;
    logic          accept, win_op;

    // Commands are only taken in IDLE, which is exactly when busy is low and done is not set
    assign accept  = (state == ST_IDLE) && cmd_valid;
    assign win_op  = cmd_e'(cmd) inside {CMD_AVG, CMD_MIRX, CMD_MIRY, CMD_MAX,
                                        CMD_MIN, CMD_ROTCW, CMD_ROTCCW};
    assign wr_next = IRB_A + AW'(1);

    assign idx_tl = AW'(win_idx(32'(px) - 32'd1, 32'(py) - 32'd1, IMG_W));
    assign idx_tr = AW'(win_idx(32'(px),         32'(py) - 32'd1, IMG_W));
    assign idx_bl = AW'(win_idx(32'(px) - 32'd1, 32'(py),         IMG_W));
    assign idx_br = AW'(win_idx(32'(px),         32'(py),         IMG_W));

    lcd_win_alu #(.DW(DW)) u_alu (
        .tl     (pix[idx_tl]),
        .tr     (pix[idx_tr]),
        .bl     (pix[idx_bl]),
        .br     (pix[idx_br]),
        .op     (cmd),
        .new_tl (new_tl),
        .new_tr (new_tr),
        .new_bl (new_bl),
        .new_br (new_br)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_LOAD;
            ld_cnt  <= '0;
            px      <= X_MID;
            py      <= Y_MID;
            busy    <= 1'b1;
            done    <= 1'b0;
            IROM_EN <= 1'b0;
            IROM_A  <= '0;
            IRB_RW  <= 1'b1;
            IRB_D   <= '0;
            IRB_A   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // ld_cnt counts addresses issued; the ROM answers one cycle later
                    if (ld_cnt < LW'(N - 1))
                        IROM_A <= AW'(ld_cnt + LW'(1));
                    if (ld_cnt == LW'(N)) begin
                        IROM_EN <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        ld_cnt <= ld_cnt + LW'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                        case (cmd_e'(cmd))
                            CMD_WRITE: begin
                                state  <= ST_WRITE;
                                IRB_RW <= 1'b0;
                                IRB_A  <= '0;
                                IRB_D  <= pix[0];
                            end
                            CMD_UP:     if (py != Y_MIN) py <= py - YW'(1);
                            CMD_DOWN:   if (py != Y_MAX) py <= py + YW'(1);
                            CMD_LEFT:   if (px != X_MIN) px <= px - XW'(1);
                            CMD_RIGHT:  if (px != X_MAX) px <= px + XW'(1);
                            CMD_CENTER: begin
                                px <= X_MID;
                                py <= Y_MID;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_WRITE: begin
                    if (IRB_A == AW'(N - 1)) begin
                        IRB_RW <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        IRB_A <= wr_next;
                        IRB_D <= pix[wr_next];
                    end
                end
                ST_DONE: ;
                default: state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_LOAD && ld_cnt != '0)
                pix[AW'(ld_cnt - LW'(1))] <= IROM_Q;
            if (accept && win_op) begin
                pix[idx_tl] <= new_tl;
                pix[idx_tr] <= new_tr;
                pix[idx_bl] <= new_bl;
                pix[idx_br] <= new_br;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl_param.sv
// ==================================================================
// tb_lcd_ctrl_param : directed bench, 8x8x8 and 16x4x10 instances  (rev 1.0)
// ==================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_ctrl_param;

    localparam int N = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // ---------------- instance A : 8x8, DW=8 ----------------
    logic       a_rst, a_cv, a_en, a_rw, a_busy, a_done;
    logic [3:0] a_cmd;
    logic [7:0] a_q, a_d;
    logic [5:0] a_ia, a_ba;
    logic [7:0] a_rom [N];
    int         a_mem [N];
    int         a_exp [N];

    lcd_ctrl_param u_a (
        .clk(clk), .reset(a_rst), .IROM_Q(a_q), .cmd(a_cmd), .cmd_valid(a_cv),
        .IROM_EN(a_en), .IROM_A(a_ia), .IRB_RW(a_rw), .IRB_D(a_d), .IRB_A(a_ba),
        .busy(a_busy), .done(a_done)
    );

    always @(posedge clk) a_q <= a_rom[a_ia];

    // ---------------- instance B : 16x4, DW=10 ----------------
    logic       b_rst, b_cv, b_en, b_rw, b_busy, b_done;
    logic [3:0] b_cmd;
    logic [9:0] b_q, b_d;
    logic [5:0] b_ia, b_ba;
    logic [9:0] b_rom [N];
    int         b_mem [N];

    lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .DW(10)) u_b (
        .clk(clk), .reset(b_rst), .IROM_Q(b_q), .cmd(b_cmd), .cmd_valid(b_cv),
        .IROM_EN(b_en), .IROM_A(b_ia), .IRB_RW(b_rw), .IRB_D(b_d), .IRB_A(b_ba),
        .busy(b_busy), .done(b_done)
    );

    always @(posedge clk) b_q <= b_rom[b_ia];

    typedef struct {
        int              ncmd;
        logic [63:0]     cmds;
        logic [3:0][7:0] idx;
        logic [3:0][7:0] val;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(input int n, input logic [63:0] c,
                                input int i0, input int i1, input int i2, input int i3,
                                input int v0, input int v1, input int v2, input int v3);
        vec_t v;
        v.ncmd = n;
        v.cmds = c;
        v.idx  = {8'(i3), 8'(i2), 8'(i1), 8'(i0)};
        v.val  = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic a_reset_load();
        a_rst = 1'b0;
        a_cv  = 1'b0;
        a_cmd = 4'd0;
        repeat (2) @(negedge clk);
        a_rst = 1'b1;
        for (int t = 0; t < 80 && a_busy; t++) @(negedge clk);
        chk("a_load_done", int'(a_busy), 0);
    endtask

    task automatic a_issue(input logic [3:0] c);
        a_cmd = c;
        a_cv  = 1'b1;
        @(negedge clk);
        a_cv = 1'b0;
        chk("a_busy_pulse_hi", int'(a_busy), 1);
        @(negedge clk);
        chk("a_busy_pulse_lo", int'(a_busy), 0);
    endtask

    // Issue WRITE and capture the IRB stream; hold >= 0 keeps that command strobed
    task automatic a_dump(input int hold);
        int e, bad;
        e = 0;
        bad = 0;
        a_cmd = 4'd0;
        a_cv  = 1'b1;
        @(negedge clk);
        a_cv = (hold >= 0);
        if (hold >= 0) a_cmd = 4'(hold);
        for (int t = 0; t < N + 8; t++) begin
            if (!a_rw) begin
                if (int'(a_ba) != e) bad++;
                a_mem[a_ba] = int'(a_d);
                e++;
            end
            if (a_done) break;
            @(negedge clk);
        end
        chk("a_wr_count", e, N);
        chk("a_wr_order", bad, 0);
        chk("a_done", int'(a_done), 1);
    endtask

    task automatic a_exp_identity();
        for (int k = 0; k < N; k++) a_exp[k] = k;
    endtask

    task automatic a_cmp(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++) if (a_mem[k] != a_exp[k]) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic a_chk_reset_outs(input string nm);
        chk({nm, "_irom_a"}, int'(a_ia), 0);
        chk({nm, "_busy"},   int'(a_busy), 1);
        chk({nm, "_irom_en"}, int'(a_en), 0);
        chk({nm, "_irb_rw"}, int'(a_rw), 1);
        chk({nm, "_irb_a"},  int'(a_ba), 0);
        chk({nm, "_irb_d"},  int'(a_d), 0);
        chk({nm, "_done"},   int'(a_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int bad, found;
        for (int k = 0; k < N; k++) begin
            a_rom[k] = 8'(k);
            b_rom[k] = 10'(1023 - k);
        end
        a_rst = 1'b0; a_cv = 1'b0; a_cmd = 4'd0;
        b_rst = 1'b0; b_cv = 1'b0; b_cmd = 4'd0;

        // Window (4,4) of the identity image holds TL=27 TR=28 BL=35 BR=36
        vt[0]  = mk(1,  64'h5,           27, 28, 35, 36,  31, 31, 31, 31);
        vt[1]  = mk(1,  64'h8,           27, 28, 35, 36,  36, 36, 36, 36);
        vt[2]  = mk(1,  64'h9,           27, 28, 35, 36,  27, 27, 27, 27);
        vt[3]  = mk(1,  64'hA,           27, 28, 35, 36,  35, 27, 36, 28);
        vt[4]  = mk(1,  64'hB,           27, 28, 35, 36,  28, 36, 27, 35);
        vt[5]  = mk(1,  64'h6,           27, 28, 35, 36,  35, 36, 27, 28);
        vt[6]  = mk(1,  64'h7,           27, 28, 35, 36,  28, 27, 36, 35);
        vt[7]  = mk(11, 64'h63331111111,  0,  1,  8,  9,   8,  9,  0,  1);
        vt[8]  = mk(11, 64'h82222244444, 54, 55, 62, 63,  63, 63, 63, 63);
        vt[9]  = mk(4,  64'h9C13,        27, 28, 35, 36,  27, 27, 27, 27);
        vt[10] = mk(4,  64'h9EDF,        27, 28, 35, 36,  27, 27, 27, 27);
        vt[11] = mk(2,  64'h54,          28, 29, 36, 37,  32, 32, 32, 32);

        // Reset values and load timing
        repeat (2) @(negedge clk);
        a_chk_reset_outs("rst");
        a_rst = 1'b1;
        bad = 0;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            if (int'(a_ia) != ((k < N) ? k : N - 1) || !a_busy || a_en) bad++;
        end
        chk("load_seq", bad, 0);
        @(negedge clk);
        chk("load_busy_n1", int'(a_busy), 0);
        chk("load_en_n1", int'(a_en), 1);
        a_dump(-1);
        a_exp_identity();
        a_cmp("plain_dump");

        // Directed command vectors
        for (int v = 0; v < 12; v++) begin
            a_reset_load();
            for (int i = 0; i < vt[v].ncmd; i++) a_issue(vt[v].cmds[i*4 +: 4]);
            a_dump(-1);
            a_exp_identity();
            for (int j = 0; j < 4; j++) begin
                a_exp[vt[v].idx[j]] = int'(vt[v].val[j]);
                chk($sformatf("vec%0d_pix%0d", v, vt[v].idx[j]),
                    a_mem[vt[v].idx[j]], int'(vt[v].val[j]));
            end
            a_cmp($sformatf("vec%0d_image", v));
        end

        // cmd_valid held across the busy cycle, then strobed throughout WRITE and after done
        a_reset_load();
        a_cmd = 4'd4;
        a_cv  = 1'b1;
        repeat (2) @(negedge clk);
        a_cv = 1'b0;
        chk("hold_busy_lo", int'(a_busy), 0);
        a_issue(4'd10);
        a_dump(10);
        repeat (5) @(negedge clk);
        chk("post_done_busy", int'(a_busy), 0);
        chk("post_done_done", int'(a_done), 1);
        a_cv = 1'b0;
        a_exp_identity();
        a_exp[28] = 36; a_exp[29] = 28; a_exp[36] = 37; a_exp[37] = 29;
        a_cmp("hold_image");

        // Reset in the middle of LOAD
        a_rst = 1'b0;
        repeat (2) @(negedge clk);
        a_rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("midload_addr20", int'(a_ia), 20);
        a_rst = 1'b0;
        @(negedge clk);
        a_chk_reset_outs("midload");
        a_rst = 1'b1;
        @(negedge clk);
        chk("midload_restart", int'(a_ia), 1);
        for (int t = 0; t < 80 && a_busy; t++) @(negedge clk);
        chk("midload_reload", int'(a_busy), 0);

        // Reset in the middle of WRITE
        a_cmd = 4'd0;
        a_cv  = 1'b1;
        @(negedge clk);
        a_cv = 1'b0;
        found = 0;
        for (int t = 0; t < 80; t++) begin
            if (!a_rw && int'(a_ba) == 30) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midwrite_reach30", found, 1);
        a_rst = 1'b0;
        @(negedge clk);
        a_chk_reset_outs("midwrite");
        a_rst = 1'b1;
        for (int t = 0; t < 80 && a_busy; t++) @(negedge clk);
        chk("midwrite_reload", int'(a_busy), 0);
        a_dump(-1);
        a_exp_identity();
        a_cmp("midwrite_image");

        // Instance B: 16x4 DW=10, pointer starts at (8,2)
        repeat (2) @(negedge clk);
        b_rst = 1'b1;
        for (int t = 0; t < 80 && b_busy; t++) @(negedge clk);
        chk("b_load_done", int'(b_busy), 0);
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            b_cmd = (i < 10) ? 4'd4 : 4'd7;
            b_cv  = 1'b1;
            @(negedge clk);
            b_cv = 1'b0;
            if (!b_busy) bad++;
            @(negedge clk);
            if (b_busy) bad++;
        end
        chk("b_busy_pulses", bad, 0);
        b_cmd = 4'd0;
        b_cv  = 1'b1;
        @(negedge clk);
        b_cv = 1'b0;
        for (int t = 0; t < N + 8; t++) begin
            if (!b_rw) b_mem[b_ba] = int'(b_d);
            if (b_done) break;
            @(negedge clk);
        end
        chk("b_done", int'(b_done), 1);
        chk("b_pix30", b_mem[30], 992);
        chk("b_pix31", b_mem[31], 993);
        chk("b_pix46", b_mem[46], 976);
        chk("b_pix47", b_mem[47], 977);
        bad = 0;
        for (int k = 0; k < N; k++)
            if (!(k == 30 || k == 31 || k == 46 || k == 47) && b_mem[k] != 1023 - k) bad++;
        chk("b_image_rest", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
